ex_mdu: RTL and testbench



---
 rtl/ex_mdu_if.sv | 25 ++
 rtl/ex_mdu.sv | 165 ++++++++++++++++
 tb/tb_ex_mdu.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/ex_mdu_if.sv
// Bundle between the ID/EX register, ctrl and the EX result mux for the RV32M unit.
// inst_i/op1_i/op2_i/rd_addr_i are sampled only in a start cycle; hold_flag_o stalls ctrl
// combinationally in that cycle; reg_wen_o is a one-cycle valid strobe qualifying rd_data_o/rd_addr_o.
interface ex_mdu_if;
  logic [31:0] inst_i;
  logic [31:0] op1_i;
  logic [31:0] op2_i;
  logic [4:0]  rd_addr_i;
  logic        hold_flag_o;
  logic        busy_o;
  logic [31:0] rd_data_o;
  logic [4:0]  rd_addr_o;
  logic        reg_wen_o;
  logic [1:0]  state_dbg;

  modport slave (
    input  inst_i, op1_i, op2_i, rd_addr_i,
    output hold_flag_o, busy_o, rd_data_o, rd_addr_o, reg_wen_o, state_dbg
  );

  modport master (
    output inst_i, op1_i, op2_i, rd_addr_i,
    input  hold_flag_o, busy_o, rd_data_o, rd_addr_o, reg_wen_o, state_dbg
  );
endinterface

// File: rtl/ex_mdu.sv
// Iterative RV32M multiply/divide unit: 32-cycle shift-add multiply and restoring divide.
// Optional MDU_FAST_MUL_EN replaces the iterative multiply with a single-cycle multiplier.
module ex_mdu (
  input  logic     clk,
  input  logic     rst,
  ex_mdu_if.slave  mdu
);
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  state_t      state, state_nxt;
  logic [2:0]  op_q;
  logic [4:0]  rd_q;
  logic [4:0]  cnt;
  logic [63:0] acc;
  logic [63:0] mcand;
  logic [31:0] mplier;
  logic [31:0] rem;
  logic [31:0] quot;
  logic [31:0] divisor;
  logic        neg_q, neg_r;
  logic        special;
  logic [31:0] special_res;

  logic [2:0]  funct3;
  logic        m_op, start, is_div, fast_path;
  logic        op1_signed, op2_signed, s1, s2;
  logic        div_zero, div_ovf, is_special;
  logic [31:0] mag1, mag2;
  logic [32:0] shifted;
  logic        qbit;
  logic [31:0] sub, rem_nxt;
  logic [63:0] prod;
  logic [31:0] quo_fix, rem_fix, result;

  assign funct3 = mdu.inst_i[14:12];
  assign m_op   = (mdu.inst_i[6:0] == 7'b0110011) && (mdu.inst_i[31:25] == 7'b0000001);
  assign start  = m_op && (state == IDLE);
  assign is_div = funct3[2];

  always_comb begin
    op1_signed = 1'b0;
    op2_signed = 1'b0;
    case (funct3)
      3'd0, 3'd1, 3'd4, 3'd6: begin
        op1_signed = 1'b1;
        op2_signed = 1'b1;
      end
      3'd2:    op1_signed = 1'b1;
      default: ;
    endcase
  end

  assign s1   = op1_signed & mdu.op1_i[31];
  assign s2   = op2_signed & mdu.op2_i[31];
  assign mag1 = s1 ? (~mdu.op1_i + 32'd1) : mdu.op1_i;
  assign mag2 = s2 ? (~mdu.op2_i + 32'd1) : mdu.op2_i;

  // Divide-by-zero and signed overflow bypass the iteration entirely.
  assign div_zero   = is_div && (mdu.op2_i == 32'd0);
  assign div_ovf    = is_div && !funct3[0] && (mdu.op1_i == 32'h8000_0000) &&
                      (mdu.op2_i == 32'hFFFF_FFFF);
  assign is_special = div_zero || div_ovf;

`ifdef MDU_FAST_MUL_EN
  logic [63:0] fast_a, fast_b, fast_prod;
  assign fast_path = !is_div;
  // Sign-extended 64x64 keeps the low 64 bits equal to the 33x33 signed product.
  assign fast_a    = {{32{s1}}, mdu.op1_i};
  assign fast_b    = {{32{s2}}, mdu.op2_i};
  assign fast_prod = fast_a * fast_b;
`else
  assign fast_path = 1'b0;
`endif

  // One restoring-division step: shift in the next dividend bit and trial-subtract.
  assign shifted = {rem, quot[31]};
  assign qbit    = (shifted >= {1'b0, divisor});
  assign sub     = shifted[31:0] - divisor;
  assign rem_nxt = qbit ? sub : shifted[31:0];

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (is_special || fast_path) ? DONE : CALC;
      CALC:    if (cnt == 5'd31) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      op_q        <= 3'd0;
      rd_q        <= 5'd0;
      cnt         <= 5'd0;
      acc         <= 64'd0;
      mcand       <= 64'd0;
      mplier      <= 32'd0;
      rem         <= 32'd0;
      quot        <= 32'd0;
      divisor     <= 32'd0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      special     <= 1'b0;
      special_res <= 32'd0;
    end else begin
      state <= state_nxt;
      if (start) begin
        op_q        <= funct3;
        rd_q        <= mdu.rd_addr_i;
        cnt         <= 5'd0;
        special     <= is_special;
        special_res <= div_zero ? (funct3[1] ? mdu.op1_i : 32'hFFFF_FFFF)
                                : (funct3[1] ? 32'd0 : 32'h8000_0000);
        acc         <= 64'd0;
        mcand       <= {32'd0, mag1};
        mplier      <= mag2;
        rem         <= 32'd0;
        quot        <= mag1;
        divisor     <= mag2;
        neg_q       <= s1 ^ s2;
        neg_r       <= s1;
`ifdef MDU_FAST_MUL_EN
        if (fast_path) begin
          acc   <= fast_prod;
          neg_q <= 1'b0;
        end
`endif
      end else if (state == CALC) begin
        cnt    <= cnt + 5'd1;
        if (mplier[0]) acc <= acc + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        rem    <= rem_nxt;
        quot   <= {quot[30:0], qbit};
      end
    end
  end

  // Sign correction is applied once, on the magnitude results, while in DONE.
  always_comb begin
    prod    = neg_q ? (~acc + 64'd1) : acc;
    quo_fix = neg_q ? (~quot + 32'd1) : quot;
    rem_fix = neg_r ? (~rem + 32'd1) : rem;
    result  = 32'd0;
    if (special) begin
      result = special_res;
    end else begin
      case (op_q)
        3'd0:                result = prod[31:0];
        3'd1, 3'd2, 3'd3:    result = prod[63:32];
        3'd4, 3'd5:          result = quo_fix;
        default:             result = rem_fix;
      endcase
    end
  end

  assign mdu.hold_flag_o = start || (state == CALC);
  assign mdu.busy_o      = (state != IDLE);
  assign mdu.reg_wen_o   = (state == DONE);
  assign mdu.rd_data_o   = (state == DONE) ? result : 32'd0;
  assign mdu.rd_addr_o   = (state == DONE) ? rd_q : 5'd0;
  assign mdu.state_dbg   = state;
endmodule

// File: tb/tb_ex_mdu.sv
// Self-checking bench for ex_mdu: directed RV32M vectors, reset abort, back-to-back ops.
// Honours MDU_FAST_MUL_EN for expected multiply latency.
module tb_ex_mdu;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk;
  logic rst;
  ex_mdu_if bus ();

  ex_mdu dut (
    .clk (clk),
    .rst (rst),
    .mdu (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int failures = 0;
  int issued = 0;
  int written = 0;

  logic [36:0] exp_q[$];
  bit          m_act = 1'b0;
  int          m_start = 0;
  int          m_done = 0;
  logic [31:0] last_wb;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a,
                                        input logic [31:0] b);
    int ia, ib;
    longint sa, sb, ua, ub;
    logic [63:0] p;
    ia = a; ib = b;
    sa = ia; sb = ib;
    ua = {32'd0, a}; ub = {32'd0, b};
    p = 64'd0;
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return ia / ib;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int latency(input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] b);
    if (f3[2] && (b == 0)) return 1;
    if (f3[2] && !f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef MDU_FAST_MUL_EN
    if (!f3[2]) return 1;
`endif
    return 33;
  endfunction

  function automatic logic [31:0] enc(input logic [2:0] f3, input logic [4:0] rd);
    return {7'b0000001, 5'd2, 5'd1, f3, rd, 7'b0110011};
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    logic e_hold, e_busy, e_wen;
    logic [36:0] e;
    if (rst) begin
      check("rst_hold", bus.hold_flag_o, 0);
      check("rst_busy", bus.busy_o, 0);
      check("rst_wen", bus.reg_wen_o, 0);
      check("rst_data", bus.rd_data_o, 0);
      check("rst_rd", bus.rd_addr_o, 0);
    end else begin
      e_hold = m_act && (cyc >= m_start) && (cyc < m_done);
      e_busy = m_act && (cyc > m_start) && (cyc <= m_done);
      e_wen  = m_act && (cyc == m_done);
      check("hold", bus.hold_flag_o, e_hold);
      check("busy", bus.busy_o, e_busy);
      check("wen", bus.reg_wen_o, e_wen);
      if (bus.reg_wen_o) begin
        written++;
        if (exp_q.size() == 0) begin
          check("wb_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("wb_data", bus.rd_data_o, e[31:0]);
          check("wb_rd", bus.rd_addr_o, e[36:32]);
        end
        last_wb = bus.rd_data_o;
      end else begin
        check("idle_data", bus.rd_data_o, 0);
        check("idle_rd", bus.rd_addr_o, 0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, output int lat);
    lat           = latency(f3, a, b);
    bus.inst_i    = enc(f3, rd);
    bus.op1_i     = a;
    bus.op2_i     = b;
    bus.rd_addr_i = rd;
    m_start       = cyc;
    m_done        = cyc + lat;
    m_act         = 1'b1;
    last_wb       = 'x;
    exp_q.push_back({rd, model(f3, a, b)});
    issued++;
  endtask

  task automatic nop_cycle(input bit inject);
    @(posedge clk);
    #1;
    bus.inst_i    = inject ? enc(3'd0, 5'd9) : NOP;
    bus.op1_i     = $urandom;
    bus.op2_i     = $urandom;
    bus.rd_addr_i = 5'($urandom_range(0, 31));
  endtask

  task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input bit has_lit,
                        input logic [31:0] lit, input bit inject);
    int lat;
    start_op(f3, a, b, rd, lat);
    if (has_lit) check({name, "_model"}, model(f3, a, b), lit);
    for (int i = 1; i <= lat; i++) nop_cycle(inject && (i == 5));
    nop_cycle(1'b0);
    if (has_lit) check(name, last_wb, lit);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    rst           = 1'b1;
    bus.inst_i    = NOP;
    bus.op1_i     = 32'd0;
    bus.op2_i     = 32'd0;
    bus.rd_addr_i = 5'd0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    nop_cycle(1'b0);
    nop_cycle(1'b0);

    run_op("mul",    3'd0, 32'd7,          32'hFFFF_FFFD, 5'd5,  1, 32'hFFFF_FFEB, 0);
    run_op("mulh",   3'd1, 32'h8000_0000,  32'h8000_0000, 5'd1,  1, 32'h4000_0000, 0);
    run_op("mulhsu", 3'd2, 32'h8000_0000,  32'h8000_0000, 5'd2,  1, 32'hC000_0000, 0);
    run_op("mulhu",  3'd3, 32'h8000_0000,  32'h8000_0000, 5'd3,  1, 32'h4000_0000, 1);
    run_op("div",    3'd4, 32'hFFFF_FFF9,  32'd2,         5'd6,  1, 32'hFFFF_FFFD, 0);
    run_op("rem",    3'd6, 32'hFFFF_FFF9,  32'd2,         5'd7,  1, 32'hFFFF_FFFF, 1);
    run_op("divu0",  3'd5, 32'h0000_1234,  32'd0,         5'd8,  1, 32'hFFFF_FFFF, 0);
    run_op("removf", 3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 5'd10, 1, 32'd0,         0);
    run_op("divovf", 3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 5'd11, 1, 32'h8000_0000, 0);
    run_op("remu0",  3'd7, 32'h0000_1234,  32'd0,         5'd12, 1, 32'h0000_1234, 0);
    run_op("divu",   3'd5, 32'd100,        32'd7,         5'd13, 1, 32'd14,        0);
    run_op("remu",   3'd7, 32'd100,        32'd7,         5'd14, 1, 32'd2,         0);
    run_op("mul_x0", 3'd0, 32'd3,          32'd5,         5'd0,  1, 32'd15,        0);
    nop_cycle(1'b0);

    // Reset on CALC cycle 10 of a DIV: outputs drop at once and no write-back follows.
    start_op(3'd4, 32'd1000, 32'd3, 5'd20, lat);
    for (int i = 1; i <= 10; i++) nop_cycle(1'b0);
    rst   = 1'b1;
    m_act = 1'b0;
    exp_q.delete();
    issued--;
    nop_cycle(1'b0);
    nop_cycle(1'b0);
    rst = 1'b0;
    repeat (40) nop_cycle(1'b0);
    run_op("mul_after_rst", 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 1, 32'hFFFF_FFEB, 0);

    // Back-to-back multiplies: second start lands in the IDLE cycle right after DONE.
    run_op("b2b_a", 3'd0, 32'd1000, 32'd1000, 5'd21, 1, 32'd1000000, 0);
    run_op("b2b_b", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd22, 1, 32'hFFFF_FFFE, 0);

    for (int i = 0; i < 6; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = (i == 3) ? 32'd0 : $urandom_range(1, 255);
      run_op("rand", 3'($urandom_range(0, 7)), a, b, 5'($urandom_range(0, 31)), 0, 32'd0, 0);
    end
    repeat (5) nop_cycle(1'b0);

    check("exp_q_empty", exp_q.size(), 0);
    check("wb_count", written, issued);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
